// File: rtl/hpm_pkg.sv
// hpm_pkg: shared CSR addresses, op encoding and read-modify-write helper for the counter bank
package hpm_pkg;
    typedef enum logic [1:0] {CSR_READ, CSR_WRITE, CSR_SET, CSR_CLEAR} csr_op_e;
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MCOUNTERH     = 12'hB80;
    localparam logic [11:0] ADDR_UCOUNTER      = 12'hC00;
    localparam logic [11:0] ADDR_UCOUNTERH     = 12'hC80;
    localparam logic [11:0] ADDR_UCOUNTER_END  = 12'hC9F;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_OVF_EN        = 12'h7C0;
    localparam logic [11:0] ADDR_OVF           = 12'h7C1;

    function automatic logic [63:0] apply_csr_op(input logic [63:0] old, input logic [63:0] wdata, input csr_op_e op);
        return op == CSR_WRITE ? wdata : op == CSR_SET ? old | wdata : op == CSR_CLEAR ? old & ~wdata : old;
    endfunction
endpackage

// File: rtl/hpm_counter_bank_if.sv
// hpm_counter_bank_if: decoded CSR access channel from the CSR unit to the counter bank
interface hpm_counter_bank_if #(parameter int XLEN = 64);
    logic            csr_valid;
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_error;
    modport master(output csr_valid, csr_addr, csr_op, csr_wdata, input csr_rdata, csr_error);
    modport slave(input csr_valid, csr_addr, csr_op, csr_wdata, output csr_rdata, csr_error);
endinterface

// File: rtl/hpm_counter.sv
// hpm_counter: 64-bit event counter with per-half write port that overrides the increment
module hpm_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        inhibit,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [63:0] wdata,
    output logic [63:0] count,
    output logic        wrap
);
    logic step;
    assign step = inc && !inhibit && !wr_lo && !wr_hi;
    assign wrap = step && &count;

    // written halves replace the count; otherwise count up when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (wr_lo || wr_hi)
            count <= {wr_hi ? wdata[63:32] : count[63:32], wr_lo ? wdata[31:0] : count[31:0]};
        else if (step)
            count <= count + 64'd1;
    end
endmodule

// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: machine-mode cycle/instret/hpm counters with event select, inhibit and overflow irq
module hpm_counter_bank
    import hpm_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int NUM_HPM    = 6,
    parameter int NUM_EVENTS = 16,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hpm_counter_bank_if.slave     csr,
    input  logic                  retire,
    input  logic [NUM_EVENTS-1:0] event_inc,
    output logic [NUM_HPM-1:0]    ovf_status,
    output logic                  ovf_irq
);
    localparam int NCNT  = NUM_HPM + 2;
    localparam int SEL_W = $clog2(NUM_EVENTS + 1);
    localparam int EXT_W = 1 << SEL_W;
    localparam logic [31:0] INH_MASK = 32'((64'd1 << (NUM_HPM + 3)) - 64'd1) & ~32'd2;

    function automatic logic [4:0] cnt_num(input int k);
        return k == 0 ? 5'd0 : k == 1 ? 5'd2 : 5'(k + 1);
    endfunction

    logic [CNT_WIDTH-1:0] cnt [NCNT];
    logic [NCNT-1:0]      wrap;
    logic [31:0]          inhibit;
    logic [SEL_W-1:0]     sel [NUM_HPM];
    logic [SEL_W-1:0]     sel_evt;
    logic [NUM_HPM-1:0]   ovf_en;
    logic [EXT_W-1:0]     ev_ext;
    logic [6:0]           blk;
    logic [4:0]           low5;
    csr_op_e              op;
    logic                 is_lo, is_hi, is_user, is_cnt, is_inh, is_evt, is_oen, is_ovf, err, wr;
    logic [63:0]          sel_cnt, cur, newv, cw;

    // decode, current-value read mux and the read-modify-write result
    always_comb begin
        blk     = csr.csr_addr[11:5];
        low5    = csr.csr_addr[4:0];
        op      = csr_op_e'(csr.csr_op);
        is_lo   = blk == ADDR_MCYCLE[11:5] || blk == ADDR_UCOUNTER[11:5];
        is_hi   = blk == ADDR_MCOUNTERH[11:5] || blk == ADDR_UCOUNTERH[11:5];
        is_user = csr.csr_addr >= ADDR_UCOUNTER && csr.csr_addr <= ADDR_UCOUNTER_END;
        is_cnt  = (is_lo || is_hi) && low5 != 5'd1;
        is_inh  = csr.csr_addr == ADDR_MCOUNTINHIBIT;
        is_evt  = blk == ADDR_MCOUNTINHIBIT[11:5] && low5 >= 5'd3;
        is_oen  = csr.csr_addr == ADDR_OVF_EN;
        is_ovf  = csr.csr_addr == ADDR_OVF;
        sel_cnt = '0;
        for (int k = 0; k < NCNT; k++)
            if (low5 == cnt_num(k)) sel_cnt = cnt[k];
        sel_evt = '0;
        for (int i = 0; i < NUM_HPM; i++)
            if (low5 == 5'(i + 3)) sel_evt = sel[i];
        cur = is_cnt ? (is_hi ? {32'd0, sel_cnt[63:32]} : XLEN == 32 ? {32'd0, sel_cnt[31:0]} : sel_cnt)
            : is_inh ? {32'd0, inhibit}
            : is_evt ? 64'(sel_evt)
            : is_oen ? 64'(ovf_en)
            : is_ovf ? 64'(ovf_status) : '0;
        err = csr.csr_valid && (!(is_cnt || is_inh || is_evt || is_oen || is_ovf)
            || (is_user && op != CSR_READ) || (is_hi && XLEN == 64));
        wr   = csr.csr_valid && op != CSR_READ && !err;
        newv = apply_csr_op(cur, 64'(csr.csr_wdata), op);
        cw   = XLEN == 64 ? newv : {newv[31:0], newv[31:0]};
        csr.csr_rdata = csr.csr_valid && !err ? XLEN'(cur) : '0;
        csr.csr_error = err;
    end

    // index 0 of the extended vector is the "no event" slot so sel=0 and sel>NUM_EVENTS read 0
    assign ev_ext = EXT_W'({event_inc, 1'b0});

    for (genvar k = 0; k < NCNT; k++) begin : g_cnt
        logic hit, inc;
        assign hit = wr && is_cnt && low5 == cnt_num(k);
        if (k == 0) begin : g_cyc
            assign inc = 1'b1;
        end else if (k == 1) begin : g_ret
            assign inc = retire;
        end else begin : g_hpm
            assign inc = ev_ext[sel[k-2]];
        end
        hpm_counter u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (inc),
            .inhibit (inhibit[cnt_num(k)]),
            .wr_lo   (hit && is_lo),
            .wr_hi   (hit && (XLEN == 64 || is_hi)),
            .wdata   (cw),
            .count   (cnt[k]),
            .wrap    (wrap[k])
        );
    end

    // control registers; a write to hpm_ovf replaces any overflow raised in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inhibit    <= '0;
            ovf_en     <= '0;
            ovf_status <= '0;
            ovf_irq    <= 1'b0;
            for (int i = 0; i < NUM_HPM; i++) sel[i] <= '0;
        end else begin
            if (wr && is_inh) inhibit <= newv[31:0] & INH_MASK;
            for (int i = 0; i < NUM_HPM; i++)
                if (wr && is_evt && low5 == 5'(i + 3)) sel[i] <= newv[SEL_W-1:0];
            if (wr && is_oen) ovf_en <= newv[NUM_HPM-1:0];
            ovf_status <= wr && is_ovf ? newv[NUM_HPM-1:0] : ovf_status | wrap[NCNT-1:2];
            ovf_irq    <= |(ovf_status & ovf_en);
        end
    end
endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb_hpm_counter_bank: scoreboard bench for the counter bank in 64-bit and 32-bit builds
module tb_hpm_counter_bank;
    import hpm_pkg::*;

    typedef struct {
        string       tag;
        logic [63:0] val;
        logic        err;
        bit          chk_val;
    } sb_t;

    logic        clk, rst_n, retire;
    logic [15:0] event_inc;
    logic [5:0]  ovf, ovf32;
    logic        irq, irq32;
    logic [63:0] m_cyc;
    int          n_run, n_fail;
    sb_t         q64[$], q32[$];

    hpm_counter_bank_if #(.XLEN(64)) bus ();
    hpm_counter_bank_if #(.XLEN(32)) bus32 ();

    hpm_counter_bank u_dut (
        .clk(clk), .rst_n(rst_n), .csr(bus), .retire(retire),
        .event_inc(event_inc), .ovf_status(ovf), .ovf_irq(irq)
    );

    hpm_counter_bank #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .csr(bus32), .retire(retire),
        .event_inc(event_inc), .ovf_status(ovf32), .ovf_irq(irq32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference mcycle of the 64-bit build: counts every cycle, a write to 0xB00 replaces it
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_cyc <= '0;
        else if (bus.csr_valid && bus.csr_addr == ADDR_MCYCLE && bus.csr_op == 2'b01)
            m_cyc <= bus.csr_wdata;
        else
            m_cyc <= m_cyc + 64'd1;
    end

    always @(negedge clk) begin
        sb_t e;
        if (bus.csr_valid) begin
            if (q64.size() == 0) chk("q64_underflow", 64'd1, 64'd0);
            else begin
                e = q64.pop_front();
                if (e.chk_val) chk({e.tag, "_rd"}, bus.csr_rdata, e.val);
                chk({e.tag, "_err"}, 64'(bus.csr_error), 64'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (bus32.csr_valid) begin
            if (q32.size() == 0) chk("q32_underflow", 64'd1, 64'd0);
            else begin
                e = q32.pop_front();
                if (e.chk_val) chk({e.tag, "_rd"}, 64'(bus32.csr_rdata), e.val);
                chk({e.tag, "_err"}, 64'(bus32.csr_error), 64'(e.err));
            end
        end
    end

    task automatic acc(input bit b32, input string tag, input logic [11:0] a, input logic [1:0] op,
                       input logic [63:0] wd, input bit cv, input logic [63:0] ev, input logic ee);
        sb_t e;
        e.tag = tag; e.val = ev; e.err = ee; e.chk_val = cv;
        if (b32) begin
            bus32.csr_valid = 1'b1; bus32.csr_addr = a; bus32.csr_op = op; bus32.csr_wdata = wd[31:0];
            q32.push_back(e);
        end else begin
            bus.csr_valid = 1'b1; bus.csr_addr = a; bus.csr_op = op; bus.csr_wdata = wd;
            q64.push_back(e);
        end
        @(posedge clk); #1;
        bus.csr_valid = 1'b0;
        bus32.csr_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] ev, input logic ee);
        acc(1'b0, tag, a, 2'b00, 64'd0, 1'b1, ev, ee);
    endtask

    task automatic wr(input string tag, input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd);
        acc(1'b0, tag, a, op, wd, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; retire = 1'b0; event_inc = '0;
        bus.csr_valid = 1'b0; bus.csr_addr = '0; bus.csr_op = '0; bus.csr_wdata = '0;
        bus32.csr_valid = 1'b0; bus32.csr_addr = '0; bus32.csr_op = '0; bus32.csr_wdata = '0;
        #1;
        chk("rst_rdata", bus.csr_rdata, 64'd0);
        chk("rst_err", 64'(bus.csr_error), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);
        rd("mcycle_10", ADDR_MCYCLE, 64'd10, 1'b0);
        rd("minstret_0", ADDR_MINSTRET, 64'd0, 1'b0);
        retire = 1'b1;
        idle(3);
        retire = 1'b0;
        rd("minstret_3", ADDR_MINSTRET, 64'd3, 1'b0);
        wr("evt3_wr", 12'h323, CSR_WRITE, 64'd2);
        rd("evt3_rd", 12'h323, 64'd2, 1'b0);
        event_inc = 16'h0002;
        idle(5);
        event_inc = '0;
        rd("hpm3_5", 12'hB03, 64'd5, 1'b0);
        rd("hpm3_user", 12'hC03, 64'd5, 1'b0);
        wr("inh_set", ADDR_MCOUNTINHIBIT, CSR_SET, 64'hA);
        rd("inh_rd", ADDR_MCOUNTINHIBIT, 64'h8, 1'b0);
        event_inc = 16'h0002;
        idle(5);
        event_inc = '0;
        rd("hpm3_inh", 12'hB03, 64'd5, 1'b0);
        wr("evt4_wr", 12'h324, CSR_WRITE, 64'd1);
        wr("oen_wr", ADDR_OVF_EN, CSR_WRITE, 64'd2);
        wr("hpm4_wr", 12'hB04, CSR_WRITE, 64'hFFFF_FFFF_FFFF_FFFE);
        event_inc = 16'h0001;
        idle(2);
        event_inc = '0;
        chk("ovf_set", 64'(ovf), 64'd2);
        chk("irq_lag", 64'(irq), 64'd0);
        idle(1);
        chk("irq_set", 64'(irq), 64'd1);
        rd("ovf_csr", ADDR_OVF, 64'd2, 1'b0);
        rd("hpm4_wrap", 12'hB04, 64'd0, 1'b0);
        wr("ovf_clr", ADDR_OVF, CSR_CLEAR, 64'd2);
        chk("ovf_clr", 64'(ovf), 64'd0);
        chk("irq_hold", 64'(irq), 64'd1);
        idle(1);
        chk("irq_clr", 64'(irq), 64'd0);
        acc(1'b0, "user_wr", ADDR_UCOUNTER, CSR_WRITE, 64'd5, 1'b1, 64'd0, 1'b1);
        rd("mcycle_model", ADDR_MCYCLE, m_cyc, 1'b0);
        rd("unimpl_hpm", 12'hB1F, 64'd0, 1'b0);
        rd("unmapped", 12'h123, 64'd0, 1'b1);
        rd("high_xlen64", ADDR_MCOUNTERH, 64'd0, 1'b1);
        wr("mcycle_wr", ADDR_MCYCLE, CSR_WRITE, 64'd100);
        rd("mcycle_100", ADDR_MCYCLE, 64'd100, 1'b0);
        rd("mcycle_101", ADDR_MCYCLE, 64'd101, 1'b0);
        acc(1'b1, "x32_hi_wr", ADDR_MCOUNTERH, CSR_WRITE, 64'd1, 1'b0, 64'd0, 1'b0);
        acc(1'b1, "x32_lo_wr", ADDR_MCYCLE, CSR_WRITE, 64'hFFFF_FFFF, 1'b0, 64'd0, 1'b0);
        acc(1'b1, "x32_precarry", ADDR_MCYCLE, CSR_READ, 64'd0, 1'b1, 64'hFFFF_FFFF, 1'b0);
        acc(1'b1, "x32_lo", ADDR_MCYCLE, CSR_READ, 64'd0, 1'b1, 64'd0, 1'b0);
        acc(1'b1, "x32_hi", ADDR_MCOUNTERH, CSR_READ, 64'd0, 1'b1, 64'd2, 1'b0);
        idle(3);
        rst_n = 1'b0;
        rd("rst_mid_mcycle", ADDR_MCYCLE, 64'd0, 1'b0);
        rd("rst_mid_oen", ADDR_OVF_EN, 64'd0, 1'b0);
        chk("rst_mid_irq", 64'(irq), 64'd0);
        rst_n = 1'b1;
        idle(2);
        rd("mcycle_restart", ADDR_MCYCLE, 64'd2, 1'b0);
        chk("q64_drain", 64'(q64.size()), 64'd0);
        chk("q32_drain", 64'(q32.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
